// File: rtl/dcompressor_pkg.sv
// Shared types and helpers for the multi-channel dynamic-range compressor.
// Pipeline records carry fields at maximum width; each instance casts down to its own WIDTH.
package dcompressor_pkg;

   localparam int MAX_W       = 32;
   localparam int MAX_CW      = 8;
   localparam int NCH_DEFAULT = 2;

   function automatic int f_cw(input int nch);
      return (nch > 1) ? $clog2(nch) : 1;
   endfunction

   localparam int CW = f_cw(NCH_DEFAULT);

   // x is the sample sign-extended to MAX_W; the result is |x| clipped to 2**(width-1)-1
   function automatic logic [MAX_W-1:0] f_sat_abs(input logic [MAX_W-1:0] x, input int width);
      logic [MAX_W-1:0] lim;
      logic [MAX_W-1:0] a;
      lim = (MAX_W'(1) << (width - 1)) - MAX_W'(1);
      a   = x[MAX_W-1] ? (~x + MAX_W'(1)) : x;
      return (a > lim) ? lim : a;
   endfunction

   typedef struct packed {
      logic              valid;
      logic [MAX_CW-1:0] chan;
      logic              sign;
      logic [MAX_W-1:0]  mag;
      logic [MAX_W-1:0]  x;
      logic              bypass;
   } stage_t;

endpackage

// File: rtl/dcompressor_env_bank.sv
// Per-channel peak envelope registers with attack/release smoothing.
// Returns the updated envelope combinationally and commits it on the clock edge when i_we is set.
module dcompressor_env_bank
#(
   parameter int NCH           = 2,
   parameter int MW            = 7,
   parameter int CH_W          = 1,
   parameter int ATTACK_SHIFT  = 1,
   parameter int RELEASE_SHIFT = 4
)(
   input  logic            i_clk,
   input  logic            i_reset_n,
   input  logic [CH_W-1:0] i_chan,
   input  logic [MW-1:0]   i_mag,
   input  logic            i_we,
   output logic [MW-1:0]   o_env
);

   logic [MW-1:0] env_q [NCH];
   logic [MW-1:0] env_d [NCH];
   logic [MW-1:0] e;

   always_comb begin
      e = '0;
      for (int c = 0; c < NCH; c++) begin
         if (32'(i_chan) == 32'(c)) e = env_q[c];
      end
      // each step is bounded by the distance to mag, so neither branch can wrap
      if (i_mag > e) o_env = e + ((i_mag - e) >> ATTACK_SHIFT);
      else           o_env = e - ((e - i_mag) >> RELEASE_SHIFT);
      env_d = env_q;
      if (i_we) begin
         for (int c = 0; c < NCH; c++) begin
            if (32'(i_chan) == 32'(c)) env_d[c] = o_env;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         for (int c = 0; c < NCH; c++) env_q[c] <= '0;
      end else begin
         env_q <= env_d;
      end
   end

endmodule

// File: rtl/dcompressor_mc.sv
// Multi-channel streaming compressor: saturating magnitude, per-channel envelope, hard-knee gain.
// Three-cycle latency, one sample per cycle, no backpressure; out-of-range channel tags are dropped.
module dcompressor_mc
   import dcompressor_pkg::*;
#(
   parameter int WIDTH         = 8,
   parameter int NCH           = 2,
   parameter int THRESHOLD     = 64,
   parameter int RATIO_SHIFT   = 2,
   parameter int ATTACK_SHIFT  = 1,
   parameter int RELEASE_SHIFT = 4,
   localparam int CH_W         = f_cw(NCH)
)(
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_valid,
   input  logic [CH_W-1:0]  i_chan,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_bypass,
   output logic             o_valid,
   output logic [CH_W-1:0]  o_chan,
   output logic [WIDTH-1:0] o_data
);

   localparam int            MW  = WIDTH - 1;
   localparam logic [MW-1:0] THR = MW'(THRESHOLD);

   stage_t           s1_d, s1_q, s2_d, s2_q;
   logic [MW-1:0]    env_new, env2_d, env2_q;
   logic [MW-1:0]    d, red, mag2, m;
   logic             o_valid_d, o_valid_q;
   logic [CH_W-1:0]  o_chan_d, o_chan_q;
   logic [WIDTH-1:0] o_data_d, o_data_q;

   always_comb begin
      s1_d        = '0;
      s1_d.valid  = i_valid && (32'(i_chan) < 32'(NCH));
      s1_d.chan   = MAX_CW'(i_chan);
      s1_d.sign   = i_data[WIDTH-1];
      s1_d.x      = MAX_W'($signed(i_data));
      s1_d.mag    = f_sat_abs(MAX_W'($signed(i_data)), WIDTH);
      s1_d.bypass = i_bypass;
   end

   // a same-channel sample one cycle behind sees the envelope committed on this edge
   dcompressor_env_bank #(
      .NCH           (NCH),
      .MW            (MW),
      .CH_W          (CH_W),
      .ATTACK_SHIFT  (ATTACK_SHIFT),
      .RELEASE_SHIFT (RELEASE_SHIFT)
   ) u_env_bank (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_chan    (CH_W'(s1_q.chan)),
      .i_mag     (MW'(s1_q.mag)),
      .i_we      (s1_q.valid),
      .o_env     (env_new)
   );

   always_comb begin
      s2_d   = s1_q;
      env2_d = env_new;
   end

   always_comb begin
      d         = (env2_q > THR) ? (env2_q - THR) : '0;
      red       = d - (d >> RATIO_SHIFT);
      mag2      = MW'(s2_q.mag);
      m         = (mag2 > red) ? (mag2 - red) : '0;
      o_valid_d = s2_q.valid;
      o_chan_d  = o_chan_q;
      o_data_d  = o_data_q;
      if (s2_q.valid) begin
         o_chan_d = CH_W'(s2_q.chan);
         if (s2_q.bypass) o_data_d = WIDTH'(s2_q.x);
         else             o_data_d = s2_q.sign ? -{1'b0, m} : {1'b0, m};
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         s1_q      <= '0;
         s2_q      <= '0;
         env2_q    <= '0;
         o_valid_q <= 1'b0;
         o_chan_q  <= '0;
         o_data_q  <= '0;
      end else begin
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         env2_q    <= env2_d;
         o_valid_q <= o_valid_d;
         o_chan_q  <= o_chan_d;
         o_data_q  <= o_data_d;
      end
   end

   assign o_valid = o_valid_q;
   assign o_chan  = o_chan_q;
   assign o_data  = o_data_q;

endmodule

// File: tb/tb_dcompressor_mc.sv
// Directed and randomized bench for dcompressor_mc against an integer model of the compressor rules.
// Built with NCH=3 so a 2-bit tag can carry the out-of-range value 3.
module tb_dcompressor_mc;

   localparam int WIDTH = 8;
   localparam int NCH   = 3;
   localparam int CW    = 2;
   localparam int THR   = 64;
   localparam int RS    = 2;
   localparam int AS    = 1;
   localparam int RLS   = 4;

   logic             clk = 1'b0;
   logic             i_reset_n;
   logic             i_valid;
   logic [CW-1:0]    i_chan;
   logic [WIDTH-1:0] i_data;
   logic             i_bypass;
   logic             o_valid;
   logic [CW-1:0]    o_chan;
   logic [WIDTH-1:0] o_data;

   dcompressor_mc #(
      .WIDTH(WIDTH), .NCH(NCH), .THRESHOLD(THR), .RATIO_SHIFT(RS),
      .ATTACK_SHIFT(AS), .RELEASE_SHIFT(RLS)
   ) dut (
      .i_clk(clk), .i_reset_n(i_reset_n), .i_valid(i_valid), .i_chan(i_chan),
      .i_data(i_data), .i_bypass(i_bypass), .o_valid(o_valid), .o_chan(o_chan),
      .o_data(o_data)
   );

   always #5 clk = ~clk;

   typedef struct { int due; int ch; int data; } exp_t;
   exp_t q[$];
   int   env_m [NCH];
   int   checks = 0, errors = 0, cyc = 0, last_ch = 0, last_data = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
      end
   endtask

   // integer model: saturating magnitude, smoothed envelope, knee with 2**RS:1 ratio
   function automatic int model(input int ch, input int x, input bit byp);
      int mag, e, d, red, m;
      mag = (x < 0) ? -x : x;
      if (mag > (1 << (WIDTH - 1)) - 1) mag = (1 << (WIDTH - 1)) - 1;
      e = env_m[ch];
      if (mag > e) e = e + (mag - e) / (1 << AS);
      else         e = e - (e - mag) / (1 << RLS);
      env_m[ch] = e;
      d   = (e > THR) ? e - THR : 0;
      red = d - d / (1 << RS);
      m   = (mag > red) ? mag - red : 0;
      if (byp) return x;
      return (x < 0) ? -m : m;
   endfunction

   task automatic tick();
      @(posedge clk);
      cyc++;
      #1;
      if (q.size() > 0 && q[0].due == cyc) begin
         check("o_valid", 32'(o_valid), 1);
         check("o_chan", 32'(o_chan), q[0].ch);
         check("o_data", 32'($signed(o_data)), q[0].data);
         last_ch   = q[0].ch;
         last_data = q[0].data;
         void'(q.pop_front());
      end else begin
         check("o_valid_idle", 32'(o_valid), 0);
         check("o_chan_hold", 32'(o_chan), last_ch);
         check("o_data_hold", 32'($signed(o_data)), last_data);
      end
   endtask

   task automatic drive(input bit v, input int ch, input int x, input bit byp, input int exp);
      i_valid  = v;
      i_chan   = CW'(ch);
      i_data   = WIDTH'(x);
      i_bypass = byp;
      if (v && ch < NCH) q.push_back('{cyc + 3, ch, exp});
      tick();
   endtask

   task automatic dsend(input int ch, input int x, input bit byp, input int exp);
      void'(model(ch, x, byp));
      drive(1'b1, ch, x, byp, exp);
   endtask

   task automatic rsend(input bit v, input int ch, input int x, input bit byp);
      int e;
      e = 0;
      if (v && ch < NCH) e = model(ch, x, byp);
      drive(v, ch, x, byp, e);
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 0, 0, 1'b0, 0);
   endtask

   task automatic do_reset();
      i_valid   = 1'b0;
      i_reset_n = 1'b0;
      #1;
      check("rst_o_valid", 32'(o_valid), 0);
      check("rst_o_data", 32'($signed(o_data)), 0);
      check("rst_o_chan", 32'(o_chan), 0);
      q.delete();
      last_ch   = 0;
      last_data = 0;
      foreach (env_m[i]) env_m[i] = 0;
      tick();
      i_reset_n = 1'b1;
      tick();
   endtask

   initial begin
      i_reset_n = 1'b1;
      i_valid   = 1'b0;
      i_chan    = '0;
      i_data    = '0;
      i_bypass  = 1'b0;
      #2;
      do_reset();

      // reset while two samples are in flight: nothing may emerge afterwards
      dsend(0, 50, 1'b0, 50);
      dsend(1, 60, 1'b0, 60);
      do_reset();
      idle(4);

      // below the knee: passes unchanged
      dsend(0, 50, 1'b0, 50);
      dsend(0, 50, 1'b0, 50);
      dsend(0, 50, 1'b0, 50);
      dsend(0, 50, 1'b0, 50);
      idle(3);

      // rising envelope above the knee, then release and channel isolation
      do_reset();
      dsend(0, 100, 1'b0, 100);
      dsend(0, 100, 1'b0, 91);
      dsend(0, 100, 1'b0, 82);
      dsend(0, 0, 1'b0, 0);
      dsend(1, 100, 1'b0, 100);
      idle(3);

      do_reset();
      dsend(0, -100, 1'b0, -100);
      dsend(0, -100, 1'b0, -91);
      dsend(0, -100, 1'b0, -82);
      idle(3);

      // most negative sample: saturates, or passes raw under bypass while env still moves
      do_reset();
      dsend(0, -128, 1'b0, -127);
      idle(3);
      do_reset();
      dsend(0, -128, 1'b1, -128);
      dsend(0, 127, 1'b0, 103);
      idle(3);

      // out-of-range tag is dropped and touches no envelope
      do_reset();
      drive(1'b1, 3, 127, 1'b0, 0);
      dsend(0, 100, 1'b0, 100);
      dsend(1, 100, 1'b0, 100);
      dsend(2, 100, 1'b0, 100);
      idle(3);

      do_reset();
      for (int i = 0; i < 600; i++) begin
         if (i == 300) do_reset();
         rsend($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
               int'($urandom_range(0, 255)) - 128, $urandom_range(0, 7) == 0);
      end
      idle(4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
